// File: rtl/ramsp_rdwr_arb.sv
// Single-port RAM access controller: posted 2-entry write buffer,
// read priority with write-starvation limit and read-after-write forwarding.
module ramsp_rdwr_arb #(
  parameter int ADDRBIT   = 11,
  parameter int WIDTH     = 32,
  parameter int WR_STARVE = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               test,
  input  logic               wr_req,
  input  logic [ADDRBIT-1:0] wr_addr,
  input  logic [WIDTH-1:0]   wr_data,
  output logic               wr_rdy,
  input  logic               rd_req,
  input  logic [ADDRBIT-1:0] rd_addr,
  output logic               rd_rdy,
  output logic               rd_vld,
  output logic [WIDTH-1:0]   rd_data,
  output logic               wbuf_empty,
  output logic [ADDRBIT-1:0] ram_a,
  output logic               ram_we,
  output logic               ram_re,
  output logic [WIDTH-1:0]   ram_di,
  input  logic [WIDTH-1:0]   ram_do,
  output logic               ram_test,
  output logic               ram_mask
);

  localparam logic [3:0] STARVE_MAX = 4'(WR_STARVE);

  logic [ADDRBIT-1:0] r_addr [2];
  logic [WIDTH-1:0]   r_data [2];
  logic               r_head;
  logic [1:0]         r_cnt;
  logic [3:0]         r_starve;
  logic               r_rd_vld;
  logic               r_fwd_hit;
  logic [WIDTH-1:0]   r_fwd_data;
  logic [WIDTH-1:0]   r_rd_hold;

  logic               w_empty;
  logic               w_full;
  logic               w_force;
  logic               w_rd_go;
  logic               w_wr_go;
  logic               w_push;
  logic               w_tail;
  logic               w_new;
  logic               w_hit_new;
  logic               w_hit_old;
  logic [WIDTH-1:0]   w_fwd_data;

  assign w_empty = (r_cnt == 2'd0);
  assign w_full  = (r_cnt == 2'd2);
  assign w_force = (r_starve == STARVE_MAX)
                 & !w_empty;

  // A read only loses to a forced write;
  // a write goes when forced or when idle.
  assign w_rd_go = !test & !w_force & rd_req;
  assign w_wr_go = !test & !w_empty
                 & (w_force | !rd_req);

  assign wr_rdy = !test & !w_full;
  assign rd_rdy = !test & !w_force;
  assign w_push = wr_req & wr_rdy;

  // Free slot sits one past head when one
  // entry is held, at head when empty.
  assign w_tail = r_head ^ r_cnt[0];
  assign w_new  = r_head ^ w_full;

  // Newest matching entry wins forwarding.
  assign w_hit_new = !w_empty
                   & (r_addr[w_new] == rd_addr);
  assign w_hit_old = w_full
                   & (r_addr[r_head] == rd_addr);
  assign w_fwd_data = w_hit_new ? r_data[w_new]
                                : r_data[r_head];

  assign wbuf_empty = w_empty;
  assign ram_test   = test;
  assign ram_mask   = 1'b0;
  assign rd_vld     = r_rd_vld;
  assign rd_data    = !r_rd_vld  ? r_rd_hold  :
                      r_fwd_hit  ? r_fwd_data :
                                   ram_do;

  // Drive RAM pins for the winning access.
  always_comb begin
    ram_we = 1'b0;
    ram_re = 1'b0;
    ram_a  = '0;
    ram_di = '0;
    unique case (1'b1)
      w_wr_go: begin
        ram_we = 1'b1;
        ram_a  = r_addr[r_head];
        ram_di = r_data[r_head];
      end
      w_rd_go: begin
        ram_re = 1'b1;
        ram_a  = rd_addr;
      end
      default: ;
    endcase
  end

  // Write buffer storage, head and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head <= 1'b0;
      r_cnt  <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        r_addr[i] <= '0;
        r_data[i] <= '0;
      end
    end else begin
      if (w_push) begin
        r_addr[w_tail] <= wr_addr;
        r_data[w_tail] <= wr_data;
      end
      if (w_wr_go)
        r_head <= ~r_head;
      case ({w_push, w_wr_go})
        2'b10:   r_cnt <= r_cnt + 2'd1;
        2'b01:   r_cnt <= r_cnt - 2'd1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Count cycles a pending write is held off.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_starve <= 4'd0;
    else if (test)
      r_starve <= r_starve;
    else if (w_wr_go | w_empty)
      r_starve <= 4'd0;
    else if (r_starve != STARVE_MAX)
      r_starve <= r_starve + 4'd1;
  end

  // Read return: valid flag, forward capture,
  // and held data between reads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_vld   <= 1'b0;
      r_fwd_hit  <= 1'b0;
      r_fwd_data <= '0;
      r_rd_hold  <= '0;
    end else begin
      r_rd_vld <= w_rd_go;
      if (w_rd_go) begin
        r_fwd_hit  <= w_hit_new | w_hit_old;
        r_fwd_data <= w_fwd_data;
      end
      if (r_rd_vld)
        r_rd_hold <= rd_data;
    end
  end

endmodule

// File: doc/ramsp_rdwr_arb.md
Name: ramsp_rdwr_arb

Overview:
Access controller that drives one single-port RAM instance (clk/a/we/re/di/do/test/mask interface) on behalf of a posted-write client and a read client. Guarantees the RAM never sees read and write in the same cycle. A 2-entry posted-write buffer absorbs writes, with read-after-write forwarding and write-starvation protection. Sits between datapath logic (e.g. per-channel context stores) and the RAM model.

Parameters:
ADDRBIT, 11, RAM address width
WIDTH, 32, RAM data width
WR_STARVE, 4, max consecutive cycles a pending write may be deferred by reads (1..15)

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
test  in  1  test mode; RAM access frozen
wr_req  in  1  write request
wr_addr  in  ADDRBIT  write address
wr_data  in  WIDTH  write data
wr_rdy  out  1  write accepted at clk edge when wr_req & wr_rdy
rd_req  in  1  read request
rd_addr  in  ADDRBIT  read address
rd_rdy  out  1  read issued this cycle when rd_req & rd_rdy
rd_vld  out  1  read data valid (1 cycle after issue)
rd_data  out  WIDTH  read data
wbuf_empty  out  1  write buffer empty
ram_a  out  ADDRBIT  RAM address
ram_we  out  1  RAM write enable
ram_re  out  1  RAM read enable
ram_di  out  WIDTH  RAM write data
ram_do  in  WIDTH  RAM registered read data
ram_test  out  1  RAM test pin
ram_mask  out  1  RAM mask pin, tied 0

Behaviour:
- Reset (async, rst=1): buffer empty (count 0), starve counter 0, rd_vld 0, rd_data 0. Combinational outputs are then: wr_rdy=1, rd_rdy=1, wbuf_empty=1, ram_we=0, ram_re=0, ram_a=0, ram_di=0, ram_test=test.
- Write buffer: 2-entry FIFO {addr,data}. wr_rdy = !test & (count<2); depends only on registered count, so no same-cycle fall-through when full. Accepted write enters at edge; earliest RAM write is the next cycle.
- Arbitration each cycle (combinational, RAM pins driven in the same cycle):
  1. test=1: no op. ram_we=ram_re=0, rd_rdy=0, wr_rdy=0; buffer and starve counter hold.
  2. force = (starve==WR_STARVE) & !empty: write head; rd_rdy=0.
  3. rd_req: read issued. ram_re=1, ram_a=rd_addr, rd_rdy=1.
  4. !empty: write head. ram_we=1, ram_a=head addr, ram_di=head data; pop at edge.
  5. Otherwise idle: ram_a=0, ram_di=0.
- rd_rdy = !test & !force (independent of rd_req).
- Invariant: ram_we & ram_re never both 1.
- Starve counter: cleared when a write issues or the buffer is empty; otherwise incremented when the buffer is non-empty and no write issues; saturates at WR_STARVE.
- Read latency: issue in cycle N gives rd_vld=1 in cycle N+1 only.
  - Without forwarding, rd_data=ram_do.
  - Forwarding: at issue, rd_addr is compared with valid buffer entries. On a match, the newest matching entry's data is registered, and in N+1 rd_data takes that data instead of ram_do.
  - A write accepted in the same cycle as a read issue is not visible to that read; the read returns the older value.
- rd_data holds its last value when rd_vld=0.
- test rising in N+1 after a read issue in N: rd_vld still pulses with the data captured at edge N.
- Simultaneous push and pop: count unchanged, FIFO order kept.
- ram_test=test; ram_mask=0.
- rst mid-operation: pending writes are discarded and an in-flight rd_vld is cancelled.

Test Plan:
- Reset, then write addr 0x0A5 = 0xDEADBEEF with no reads → ram_we=1, ram_a=0x0A5 in the cycle after accept, wbuf_empty=1 after. Later read 0x0A5 → rd_vld 1 cycle after issue, rd_data=0xDEADBEEF.
- Write addr 3=0x11, then addr 3=0x22, with rd_req held on addr 3 → rd_data=0x22 (newest forwarded); ram_we never asserted while reads win.
- WR_STARVE=4, rd_req held continuously, one write accepted at edge N → reads issued in N+1..N+4; in N+5 rd_rdy=0 and ram_we=1 for one cycle; reads resume in N+6.
- rd_req held, three back-to-back wr_req → first two accepted, wr_rdy=0 after, third accepted only after a forced write pops an entry.
- test=1 for 5 cycles with 2 pending writes → ram_test=1, no ram_we/ram_re, rd_rdy=wr_rdy=0. After test=0, both writes drain in order.
- Assert rst with 2 pending writes and a read in flight → rd_vld=0 and wbuf_empty=1 immediately; no RAM write follows. Check the ram_we&ram_re=0 invariant throughout.
